counter_spi_streamer: RTL and testbench

COUNTER_SPI_STREAMER -- requirements
Module: counter_spi_streamer

---
 rtl/counter_spi_pkg.sv | 7 +
 rtl/counter_spi_streamer_if.sv | 10 +
 rtl/tick_gen_div.sv | 13 +
 rtl/counter_spi_streamer.sv | 81 ++++++++
 tb/tb_counter_spi_streamer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/counter_spi_pkg.sv
// counter_spi_pkg: shared FSM state encoding and frame sizing helper for the counter SPI streamer
package counter_spi_pkg;
  typedef enum logic [2:0] {IDLE, LATCH, SEND, WAIT_DONE, WAIT_READY} state_t;
  function automatic int bytes_for(input int width);
    return (width + 7) / 8;
  endfunction
endpackage

// File: rtl/counter_spi_streamer_if.sv
// counter_spi_streamer_if: byte handshake between the streamer and an SPI master
interface counter_spi_streamer_if;
  logic [7:0] tx_data;
  logic start;
  logic ss_n;
  logic tx_ready;
  logic done;
  modport master (output tx_data, start, ss_n, input tx_ready, done);
  modport slave (input tx_data, start, ss_n, output tx_ready, done);
endinterface

// File: rtl/tick_gen_div.sv
// tick_gen_div: one-cycle tick every TICK_DIV clocks, divider cleared by active-low reset
module tick_gen_div #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] div;
  always_ff @(posedge clk) div <= (!reset || tick) ? '0 : div + 1'b1;
  assign tick = div == W'(TICK_DIV - 1);
endmodule

// File: rtl/counter_spi_streamer.sv
// counter_spi_streamer: tick-driven up/down counter that streams each new sample MSB-first over SPI
module counter_spi_streamer
  import counter_spi_pkg::*;
#(
  parameter int CNT_WIDTH = 14,
  parameter int CNT_MAX   = 9999,
  parameter int TICK_DIV  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 run_toggle,
  input  logic                 dir,
  counter_spi_streamer_if.master spi,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 running,
  output logic                 overrun
);
  localparam int NUM_BYTES = bytes_for(CNT_WIDTH);
  localparam int SW = NUM_BYTES * 8;
  localparam int IW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_WIDTH-1:0] MAX = CNT_WIDTH'(CNT_MAX);
  state_t state, next;
  logic tick;
  logic last;
  logic [SW-1:0] shadow;
  logic [IW-1:0] idx;
  tick_gen_div #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .reset(reset), .tick(tick));
  function automatic logic [7:0] byte_at(input logic [SW-1:0] v, input logic [IW-1:0] i);
    return 8'(v >> (8 * (NUM_BYTES - 1 - int'(i))));
  endfunction
  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      running <= 1'b0;
      overrun <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      running <= running ^ run_toggle;
      if (tick && (state != IDLE || !spi.tx_ready)) overrun <= 1'b1;
      if (tick && running)
        count <= dir ? (count == '0 ? MAX : count - 1'b1) : (count == MAX ? '0 : count + 1'b1);
    end
  end
  // The frame reads only the shadow copy, so clear or ticks mid-frame cannot corrupt it
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      shadow      <= '0;
      spi.tx_data <= '0;
    end else begin
      state <= next;
      if (state == LATCH) begin
        shadow      <= SW'(count);
        idx         <= '0;
        spi.tx_data <= byte_at(SW'(count), '0);
      end
      if (state == WAIT_DONE && spi.done && !last) begin
        idx         <= idx + 1'b1;
        spi.tx_data <= byte_at(shadow, idx + 1'b1);
      end
    end
  end
  assign last = idx == IW'(NUM_BYTES - 1);
  always_comb begin
    next = state;
    unique case (state)
      IDLE:       next = tick && spi.tx_ready ? LATCH : IDLE;
      LATCH:      next = SEND;
      SEND:       next = WAIT_DONE;
      WAIT_DONE:  next = !spi.done ? WAIT_DONE : last ? IDLE : WAIT_READY;
      WAIT_READY: next = spi.tx_ready ? SEND : WAIT_READY;
      default:    next = IDLE;
    endcase
  end
  assign spi.start = state == SEND;
  assign spi.ss_n  = !(state inside {SEND, WAIT_DONE, WAIT_READY});
endmodule

// File: tb/tb_counter_spi_streamer.sv
// tb_counter_spi_streamer: directed ticks with a byte scoreboard checked by an independent SPI monitor
module tb_counter_spi_streamer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_a = 1'b0, reset_b = 1'b0, clear = 1'b0, run_toggle = 1'b0, dir = 1'b0;
  counter_spi_streamer_if sif_a ();
  counter_spi_streamer_if sif_b ();
  logic [13:0] count_a;
  logic [19:0] count_b;
  logic running_a, overrun_a, running_b, overrun_b;
  counter_spi_streamer #(.CNT_WIDTH(14), .CNT_MAX(9999), .TICK_DIV(40)) dut_a (
    .clk(clk), .reset(reset_a), .clear(clear), .run_toggle(run_toggle), .dir(dir),
    .spi(sif_a), .count(count_a), .running(running_a), .overrun(overrun_a));
  counter_spi_streamer #(.CNT_WIDTH(20), .CNT_MAX(999999), .TICK_DIV(10)) dut_b (
    .clk(clk), .reset(reset_b), .clear(clear), .run_toggle(run_toggle), .dir(dir),
    .spi(sif_b), .count(count_b), .running(running_b), .overrun(overrun_b));
  int checks = 0, errors = 0;
  int cyc_a = 0, cyc_b = 0;
  int done_dly_a = 16;
  int frames_a = 0, frames_b = 0, win_a = 0, win_b = 0;
  int last_a = 0, last_b = 0;
  logic [7:0] q_a[$], q_b[$];
  // Bench-side cycle count since reset release; ticks land on the last cycle of each period
  always @(posedge clk) begin
    cyc_a <= reset_a ? cyc_a + 1 : 0;
    cyc_b <= reset_b ? cyc_b + 1 : 0;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  function automatic logic [31:0] cnt(input bit sel);
    return sel ? 32'(count_b) : 32'(count_a);
  endfunction
  task automatic do_tick(input bit sel, input logic d, input logic rdy, input int exp,
                         input logic [23:0] frame, input int nb);
    do @(negedge clk); while (sel ? (cyc_b % 10 != 9) : (cyc_a % 40 != 39));
    chk(sel ? "count_b_pre_tick" : "count_a_pre_tick", cnt(sel), sel ? last_b : last_a);
    dir = d;
    sif_a.tx_ready = rdy;
    sif_b.tx_ready = rdy;
    for (int i = nb - 1; i >= 0; i--)
      if (sel) q_b.push_back(frame[8*i +: 8]);
      else q_a.push_back(frame[8*i +: 8]);
    if (nb > 0) begin
      if (sel) frames_b++;
      else frames_a++;
    end
    @(negedge clk);
    sif_a.tx_ready = 1'b1;
    sif_b.tx_ready = 1'b1;
    chk(sel ? "count_b_post_tick" : "count_a_post_tick", cnt(sel), exp);
    if (sel) last_b = exp;
    else last_a = exp;
  endtask
  task automatic chk_reset_a(input string tag);
    chk({tag, "_count"}, 32'(count_a), 0);
    chk({tag, "_running"}, 32'(running_a), 0);
    chk({tag, "_overrun"}, 32'(overrun_a), 0);
    chk({tag, "_tx_data"}, 32'(sif_a.tx_data), 0);
    chk({tag, "_start"}, 32'(sif_a.start), 0);
    chk({tag, "_ss_n"}, 32'(sif_a.ss_n), 1);
  endtask
  initial begin
    sif_a.done = 1'b0;
    forever begin
      @(negedge clk);
      if (sif_a.start) begin
        repeat (done_dly_a) @(negedge clk);
        sif_a.done = 1'b1;
        @(negedge clk);
        sif_a.done = 1'b0;
      end
    end
  end
  initial begin
    sif_b.done = 1'b0;
    forever begin
      @(negedge clk);
      if (sif_b.start) begin
        @(negedge clk);
        sif_b.done = 1'b1;
        @(negedge clk);
        sif_b.done = 1'b0;
      end
    end
  end
  initial begin
    logic prev_a = 1'b1, prev_b = 1'b1;
    forever begin
      @(negedge clk);
      if (sif_a.start) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL start_a: unexpected start with tx_data 0x%0h, expected none", sif_a.tx_data);
        end else chk("tx_data_a", 32'(sif_a.tx_data), 32'(q_a.pop_front()));
      end
      if (sif_b.start) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL start_b: unexpected start with tx_data 0x%0h, expected none", sif_b.tx_data);
        end else chk("tx_data_b", 32'(sif_b.tx_data), 32'(q_b.pop_front()));
      end
      if (prev_a && !sif_a.ss_n) win_a++;
      if (prev_b && !sif_b.ss_n) win_b++;
      prev_a = sif_a.ss_n;
      prev_b = sif_b.ss_n;
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end
  initial begin
    sif_a.tx_ready = 1'b1;
    sif_b.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_a("reset_a");
    chk("reset_b_count", 32'(count_b), 0);
    chk("reset_b_ss_n", 32'(sif_b.ss_n), 1);
    reset_a = 1'b1;
    run_toggle = 1'b1;
    @(negedge clk);
    run_toggle = 1'b0;
    chk("running_after_toggle", 32'(running_a), 1);
    do_tick(0, 0, 1, 1, 24'h000001, 2);
    do_tick(0, 0, 1, 2, 24'h000002, 2);
    do_tick(0, 0, 1, 3, 24'h000003, 2);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("count_after_clear_mid_frame", 32'(count_a), 0);
    last_a = 0;
    do_tick(0, 1, 1, 9999, 24'h00270F, 2);
    do_tick(0, 0, 1, 0, 24'h000000, 2);
    do_tick(0, 0, 0, 1, 24'h000000, 0);
    chk("overrun_not_ready", 32'(overrun_a), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("count_after_clear", 32'(count_a), 0);
    chk("overrun_after_clear", 32'(overrun_a), 0);
    last_a = 0;
    done_dly_a = 45;
    do_tick(0, 0, 1, 1, 24'h000001, 2);
    do_tick(0, 0, 1, 2, 24'h000000, 0);
    chk("overrun_busy", 32'(overrun_a), 1);
    do_tick(0, 0, 1, 3, 24'h000000, 0);
    done_dly_a = 16;
    do_tick(0, 0, 1, 4, 24'h000004, 2);
    clear = 1'b1;
    run_toggle = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    run_toggle = 1'b0;
    chk("running_clear_and_toggle", 32'(running_a), 1);
    chk("count_clear_and_toggle", 32'(count_a), 0);
    chk("overrun_clear_and_toggle", 32'(overrun_a), 0);
    last_a = 0;
    do_tick(0, 0, 1, 1, 24'h000000, 1);
    repeat (9) @(negedge clk);
    reset_a = 1'b0;
    @(negedge clk);
    chk_reset_a("abort_a");
    repeat (20) @(negedge clk);
    reset_b = 1'b1;
    run_toggle = 1'b1;
    @(negedge clk);
    run_toggle = 1'b0;
    chk("running_b_after_toggle", 32'(running_b), 1);
    do_tick(1, 1, 1, 999999, 24'h0F423F, 3);
    do_tick(1, 1, 1, 999998, 24'h0F423E, 3);
    do_tick(1, 0, 1, 999999, 24'h0F423F, 3);
    repeat (8) @(negedge clk);
    reset_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_a_drained", 32'(q_a.size()), 0);
    chk("queue_b_drained", 32'(q_b.size()), 0);
    chk("ss_n_windows_a", 32'(win_a), 32'(frames_a));
    chk("ss_n_windows_b", 32'(win_b), 32'(frames_b));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
